// File: rtl/m_ext_sequencer_if.sv
// Launch/result bus between the M-extension sequencer and the shared multiplier/divider units.
interface m_ext_sequencer_if;
    logic        mul_start;
    logic        div_start;
    logic        div_abort;
    logic [2:0]  unit_op;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic [31:0] mul_result;
    logic        div_done;
    logic [31:0] div_result;

    modport master (
        output mul_start, div_start, div_abort, unit_op, unit_a, unit_b,
        input  mul_result, div_done, div_result
    );

    modport slave (
        input  mul_start, div_start, div_abort, unit_op, unit_a, unit_b,
        output mul_result, div_done, div_result
    );
endinterface

// File: rtl/m_ext_sequencer.sv
// EX-stage sequencer for MUL/DIV/REM: launches the pipelined multiplier or iterative divider,
// resolves divide special cases locally, and holds the result until the instruction advances.
module m_ext_sequencer #(
    parameter int MUL_LATENCY = 3,
    parameter int MAX_CYCLES  = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [2:0]          funct3,
    input  logic [31:0]         rs1_data,
    input  logic [31:0]         rs2_data,
    input  logic                flush,
    input  logic                advance,
    m_ext_sequencer_if.master   unit,
    output logic                done,
    output logic [31:0]         rd_data,
    output logic                ex_stall,
    output logic                timeout_err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MUL_WAIT = 2'd1;
    localparam logic [1:0] DIV_WAIT = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam int CW = $clog2(MAX_CYCLES + MUL_LATENCY + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY);
    localparam logic [CW-1:0] DIV_LAST = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] counter;
    logic [2:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;

    logic          accept;
    logic          is_div;
    logic          div_by_zero;
    logic          div_overflow;
    logic          div_special;
    logic          div_timeout;
    logic [31:0]   special_result;

    assign accept       = (state == IDLE) && req && !flush;
    assign is_div       = funct3[2];
    assign div_by_zero  = (rs2_data == 32'h0000_0000);
    // Only signed DIV/REM overflow; DIVU/REMU of the same operands is ordinary arithmetic.
    assign div_overflow = !funct3[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    assign div_special  = is_div && (div_by_zero || div_overflow);
    assign div_timeout  = (state == DIV_WAIT) && (counter == DIV_LAST) && !unit.div_done;

    always_comb begin
        special_result = 32'h0000_0000;
        if (div_by_zero) begin
            special_result = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        end else begin
            special_result = funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // Operands appear on the bus in the launch cycle itself so the units see them with the start pulse.
    assign unit.mul_start = accept && !is_div;
    assign unit.div_start = accept && is_div && !div_special;
    assign unit.div_abort = (state == DIV_WAIT) && (flush || div_timeout);
    assign unit.unit_op   = accept ? funct3   : op_q;
    assign unit.unit_a    = accept ? rs1_data : a_q;
    assign unit.unit_b    = accept ? rs2_data : b_q;

    assign done     = (state == DONE);
    assign ex_stall = req && !done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            counter     <= '0;
            op_q        <= 3'd0;
            a_q         <= 32'h0000_0000;
            b_q         <= 32'h0000_0000;
            rd_data     <= 32'h0000_0000;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= funct3;
                        a_q  <= rs1_data;
                        b_q  <= rs2_data;
                        if (!is_div) begin
                            state       <= MUL_WAIT;
                            counter     <= CNT_ONE;
                            timeout_err <= 1'b0;
                        end else if (div_special) begin
                            state   <= DONE;
                            rd_data <= special_result;
                        end else begin
                            state       <= DIV_WAIT;
                            counter     <= CNT_ONE;
                            timeout_err <= 1'b0;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (flush) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else if (counter == MUL_LAST) begin
                        state   <= DONE;
                        counter <= '0;
                        rd_data <= unit.mul_result;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                DIV_WAIT: begin
                    if (flush) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else if (unit.div_done) begin
                        state   <= DONE;
                        counter <= '0;
                        rd_data <= unit.div_result;
                    end else if (counter == DIV_LAST) begin
                        state       <= DONE;
                        counter     <= '0;
                        rd_data     <= 32'h0000_0000;
                        timeout_err <= 1'b1;
                    end else begin
                        counter <= counter + CNT_ONE;
                    end
                end
                DONE: begin
                    if (flush || advance) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
